output_buffer_logic: RTL and testbench

//  Transmit side of the byte-serial packet link. Queues 32-bit pkt_t packets from the

---
 rtl/output_buffer_logic_pkg.sv | 16 +
 rtl/output_buffer_logic_pkt_fifo.sv | 62 ++++++
 rtl/output_buffer_logic.sv | 107 ++++++++++
 tb/tb_output_buffer_logic.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_logic_pkg.sv
// Shared types for the byte-serial transmit path: packet layout, byte geometry and tx states.
package output_buffer_logic_pkg;

    localparam int PKT_BYTES = 4;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = $clog2(PKT_BYTES) + 1;

    // Byte 0 is the most significant byte and goes out on the wire first.
    typedef logic [0:PKT_BYTES-1][BYTE_W-1:0] pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/output_buffer_logic_pkt_fifo.sv
// Synchronous packet FIFO; writes while full and reads while empty are ignored.
module pkt_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   we_i,
    input  T                       wr_data_i,
    input  logic                   re_i,
    output T                       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // full/empty come from the count before the edge, so a write while full is
    // dropped even if a pop happens in the same cycle.
    assign wr_en = we_i && !full_o;
    assign rd_en = re_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/output_buffer_logic.sv
// Transmit side of the byte-serial link: queues packets and sends each as a
// 4-byte put/payload frame followed by at least GAP_CYCLES idle cycles.
module output_buffer_logic
    import output_buffer_logic_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pkt_in,
    input  logic        pkt_in_valid,
    input  logic        dst_full,
    output logic        full,
    output logic        drained,
    output logic        overflow,
    output logic        put,
    output logic [7:0]  payload
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t              state_q;
    pkt_t                   shift_q;
    logic [CNT_W-1:0]       byte_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic                   put_q;
    logic [BYTE_W-1:0]      payload_q;
    logic                   overflow_q;
    logic                   overflow_d;

    pkt_t                   fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    pkt_fifo #(
        .DEPTH (DEPTH),
        .T     (pkt_t)
    ) u_pkt_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .we_i      (pkt_in_valid),
        .wr_data_i (pkt_t'(pkt_in)),
        .re_i      (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // dst_full only gates the start of a frame; once started, a frame always completes.
    assign pop        = (state_q == IDLE) && !fifo_empty && !dst_full && (gap_cnt_q == '0);
    assign overflow_d = pkt_in_valid && fifo_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            put_q      <= 1'b0;
            payload_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q    <= fifo_head;
                        put_q      <= 1'b1;
                        payload_q  <= fifo_head[0];
                        byte_cnt_q <= CNT_W'(1);
                        state_q    <= SEND;
                    end else begin
                        put_q <= 1'b0;
                        if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                SEND: begin
                    if (byte_cnt_q == CNT_W'(PKT_BYTES)) begin
                        put_q      <= 1'b0;
                        payload_q  <= '0;
                        byte_cnt_q <= '0;
                        gap_cnt_q  <= GAP_W'(GAP_CYCLES - 1);
                        state_q    <= IDLE;
                    end else begin
                        payload_q  <= shift_q[byte_cnt_q[CNT_W-2:0]];
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) overflow_q <= 1'b0;
        else          overflow_q <= overflow_d;
    end

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign put      = put_q;
    assign payload  = payload_q;
    assign drained  = (state_q == IDLE) && (fifo_count == '0) && (gap_cnt_q == '0) && !put_q;

endmodule

// File: tb/tb_output_buffer_logic.sv
// Bench for output_buffer_logic: two instances (GAP_CYCLES=1 and 3) with a byte scoreboard each.
module tb_output_buffer_logic;

    logic        clock;
    logic        reset_n;
    logic [31:0] pkt_in0, pkt_in1;
    logic        valid0, valid1;
    logic        dst_full0, dst_full1;
    logic        full0, full1;
    logic        drained0, drained1;
    logic        overflow0, overflow1;
    logic        put0, put1;
    logic [7:0]  payload0, payload1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int gaps0[$];
    int gaps1[$];
    int rises0[$];

    output_buffer_logic #(.DEPTH(4), .GAP_CYCLES(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .pkt_in(pkt_in0), .pkt_in_valid(valid0),
        .dst_full(dst_full0), .full(full0), .drained(drained0), .overflow(overflow0),
        .put(put0), .payload(payload0)
    );

    output_buffer_logic #(.DEPTH(4), .GAP_CYCLES(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .pkt_in(pkt_in1), .pkt_in_valid(valid1),
        .dst_full(dst_full1), .full(full1), .drained(drained1), .overflow(overflow1),
        .put(put1), .payload(payload1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame monitors: compare each transmitted byte with the scoreboard, check
    // frame length and log idle gaps between consecutive frames.
    int  run0 = 0, low0 = 0, run1 = 0, low1 = 0;
    bit  prev0 = 0, have0 = 0, prev1 = 0, have1 = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev0 = 0; run0 = 0; low0 = 0; have0 = 0;
        end else begin
            if (put0) begin
                if (!prev0) begin
                    rises0.push_back(cyc);
                    if (have0) gaps0.push_back(low0);
                    run0 = 0;
                end
                run0++;
                if (exp0.size() == 0) check_val("spurious_put0", int'(put0), 0);
                else                  check_val("payload0", int'(payload0), int'(exp0.pop_front()));
            end else begin
                if (prev0) begin
                    check_val("frame_len0", run0, 4);
                    have0 = 1;
                    low0  = 0;
                end
                low0++;
            end
            prev0 = put0;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            prev1 = 0; run1 = 0; low1 = 0; have1 = 0;
        end else begin
            if (put1) begin
                if (!prev1) begin
                    if (have1) gaps1.push_back(low1);
                    run1 = 0;
                end
                run1++;
                if (exp1.size() == 0) check_val("spurious_put1", int'(put1), 0);
                else                  check_val("payload1", int'(payload1), int'(exp1.pop_front()));
            end else begin
                if (prev1) begin
                    check_val("frame_len1", run1, 4);
                    have1 = 1;
                    low1  = 0;
                end
                low1++;
            end
            prev1 = put1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send0(input logic [31:0] p, input bit expect_tx);
        pkt_in0 = p;
        valid0  = 1'b1;
        if (expect_tx)
            for (int k = 0; k < 4; k++) exp0.push_back(p[31-8*k -: 8]);
        tick();
        valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] p);
        pkt_in1 = p;
        valid1  = 1'b1;
        for (int k = 0; k < 4; k++) exp1.push_back(p[31-8*k -: 8]);
        tick();
        valid1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sel == 1'b0 && exp0.size() == 0 && drained0) break;
            if (sel == 1'b1 && exp1.size() == 0 && drained1) break;
            tick();
        end
        if (sel == 1'b0) begin
            check_val({tag, "_drained"}, int'(drained0), 1);
            check_val({tag, "_sb_left"}, exp0.size(), 0);
        end else begin
            check_val({tag, "_drained"}, int'(drained1), 1);
            check_val({tag, "_sb_left"}, exp1.size(), 0);
        end
    endtask

    initial begin
        int n, c0;
        logic [31:0] t4 [5];
        t4[0] = 32'h0102_0304; t4[1] = 32'h1112_1314; t4[2] = 32'h2122_2324;
        t4[3] = 32'h3132_3334; t4[4] = 32'hBADB_AD00;

        reset_n = 1'b0;
        pkt_in0 = '0; valid0 = 1'b0; dst_full0 = 1'b0;
        pkt_in1 = '0; valid1 = 1'b0; dst_full1 = 1'b0;
        repeat (3) tick();
        check_val("rst_put", int'(put0), 0);
        check_val("rst_payload", int'(payload0), 0);
        check_val("rst_overflow", int'(overflow0), 0);
        check_val("rst_full", int'(full0), 0);
        check_val("rst_drained", int'(drained0), 1);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: single packet, byte0 two cycles after the write
        n  = rises0.size();
        c0 = cyc;
        send0(32'hDEADBEEF, 1'b1);
        wait_done(1'b0, "t1");
        check_val("t1_rise_cnt", rises0.size() - n, 1);
        if (rises0.size() > n) check_val("t1_latency", rises0[n] - c0, 2);

        // 2: two back-to-back packets, one idle cycle between frames
        n = gaps0.size();
        send0(32'hA1B2C3D4, 1'b1);
        send0(32'h11223344, 1'b1);
        wait_done(1'b0, "t2");
        check_val("t2_gap_cnt", gaps0.size() - n, 2);
        if (gaps0.size() >= n + 2) check_val("t2_gap", gaps0[n+1], 1);

        // 3: dst_full holds off a frame start, but not a frame in progress
        dst_full0 = 1'b1;
        n = rises0.size();
        send0(32'hCAFE_F00D, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_val("t3_hold_put", int'(put0), 0);
            tick();
        end
        dst_full0 = 1'b0;
        c0 = cyc;
        tick();
        tick();
        dst_full0 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("t3_sb_left", exp0.size(), 0);
        if (rises0.size() > n) check_val("t3_start", rises0[n] - c0, 1);
        else                   check_val("t3_started", rises0.size() - n, 1);
        dst_full0 = 1'b0;
        wait_done(1'b0, "t3");

        // 4: fill the FIFO behind dst_full, fifth write overflows and is dropped
        dst_full0 = 1'b1;
        n = gaps0.size();
        for (int i = 0; i < 5; i++) begin
            send0(t4[i], i < 4);
            if (i == 3) begin
                check_val("t4_full", int'(full0), 1);
                check_val("t4_no_ovf", int'(overflow0), 0);
            end
            if (i == 4) check_val("t4_ovf", int'(overflow0), 1);
        end
        tick();
        check_val("t4_ovf_pulse", int'(overflow0), 0);
        check_val("t4_still_full", int'(full0), 1);
        dst_full0 = 1'b0;
        wait_done(1'b0, "t4");
        check_val("t4_gap_cnt", gaps0.size() - n, 4);
        for (int i = 1; i < 4; i++)
            if (gaps0.size() > n + i) check_val("t4_gap", gaps0[n+i], 1);

        // 5: reset mid-frame abandons it immediately
        send0(32'h5A5B_5C5D, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (put0) break;
            tick();
        end
        check_val("t5_started", int'(put0), 1);
        tick();
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_put", int'(put0), 0);
        check_val("t5_rst_payload", int'(payload0), 0);
        exp0.delete();
        exp1.delete();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_val("t5_idle_put", int'(put0), 0);
        check_val("t5_drained", int'(drained0), 1);

        // 6: GAP_CYCLES=3 instance, three queued packets
        send1(32'h7071_7273);
        send1(32'h8081_8283);
        send1(32'h9091_9293);
        wait_done(1'b1, "t6");
        check_val("t6_gap_cnt", gaps1.size(), 2);
        for (int i = 0; i < gaps1.size(); i++) check_val("t6_gap", gaps1[i], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
